ewrapper_io_rx_deser: RTL and testbench

//  Receive-side counterpart of the slow-path LVDS transmitter. Lanes 0-7 carry data and lane 8

---
 rtl/ewrapper_io_rx_deser.sv | 155 +++++++++++++++
 tb/tb_ewrapper_io_rx_deser.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ewrapper_io_rx_deser.sv
// ewrapper_io_rx_deser
//   Receive-side deserializer for the slow-path LVDS link. Lanes 0-7 carry data
//   and lane 8 carries the frame pattern. Each fast clock the IDDR delivers two
//   bits per lane (even slot first, then odd). The block finds the frame lane's
//   rising edge after a long enough zero run. It then assembles 8 bits per lane,
//   MSB first, into one 72-bit word every 4 cycles, and checks the frame byte.
//
// Ports
//   CLK_IN              fast clock (IDDR clock)
//   IO_RESET_N          asynchronous active-low reset
//   DATA_EVEN_IN[8:0]   per-lane bit received first this cycle (lane 8 = frame)
//   DATA_ODD_IN[8:0]    per-lane bit received second this cycle
//   DATA_OUT_TO_DEVICE  lane k byte at [8k+7:8k], bit 8k+7 received earliest
//   DATA_VALID          one-cycle strobe, new word on DATA_OUT_TO_DEVICE
//   RX_LOCKED           high while locked to a frame
//   BIT_OFFSET          0: words start on even slot, 1: on odd slot
//   ALIGN_ERR           one-cycle strobe, frame byte neither 0xFF nor 0x00
//   ERR_CNT             saturating count of ALIGN_ERR strobes
module ewrapper_io_rx_deser #(
  parameter int IDLE_MIN  = 8,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK_IN,
  input  logic                 IO_RESET_N,
  input  logic [8:0]           DATA_EVEN_IN,
  input  logic [8:0]           DATA_ODD_IN,
  output logic [71:0]          DATA_OUT_TO_DEVICE,
  output logic                 DATA_VALID,
  output logic                 RX_LOCKED,
  output logic                 BIT_OFFSET,
  output logic                 ALIGN_ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT
);

  localparam int         NLANES     = 9;
  localparam logic [3:0] IDLE_MIN_L = 4'(IDLE_MIN);
  // After an end-of-frame byte the trailing zeros count as a full idle run,
  // so back-to-back frames can lock again immediately.
  localparam logic [3:0] EOF_ZRUN   = 4'd8;

  typedef enum logic {ST_HUNT = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [1:0]           phase_q, phase_d;
  logic [3:0]           zrun_q, zrun_d;
  logic [3:0]           zrun_even, zrun_odd;
  logic                 offset_q, offset_d;
  // Only 7 bits of past history plus the current pair are ever needed to
  // cover a word window at either bit offset.
  logic [NLANES-1:0][6:0] hist_q;
  logic [NLANES-1:0][8:0] hist_d;
  logic [71:0]          word;
  logic [71:0]          data_q;
  logic                 valid_q, err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;
  logic                 edge_even, edge_odd, complete, eof, emit, bad;
  logic                 rx_locked;

  // Per-lane history and word window. At offset 1 the current odd bit already
  // belongs to the next word, so the window sits one bit further back.
  genvar gi;
  generate
    for (gi = 0; gi < NLANES; gi++) begin : g_lane
      assign hist_d[gi]      = {hist_q[gi], DATA_EVEN_IN[gi], DATA_ODD_IN[gi]};
      assign word[8*gi +: 8] = offset_q ? hist_d[gi][8:1] : hist_d[gi][7:0];
    end
  endgenerate

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Zero-run after the even bit and after the odd bit, in arrival order.
  assign zrun_even = DATA_EVEN_IN[8] ? 4'd0 : sat_inc(zrun_q);
  assign zrun_odd  = DATA_ODD_IN[8]  ? 4'd0 : sat_inc(zrun_even);

  // Even slot is checked first, so it wins when both slots could qualify.
  assign edge_even = (state_q == ST_HUNT) && DATA_EVEN_IN[8] && (zrun_q >= IDLE_MIN_L);
  assign edge_odd  = (state_q == ST_HUNT) && !DATA_EVEN_IN[8] && DATA_ODD_IN[8] &&
                     (zrun_even >= IDLE_MIN_L);

  // Offset 0 words end on the odd slot at phase 3; offset 1 words end on the
  // even slot one cycle later, which wraps to phase 0.
  assign complete = (state_q == ST_LOCKED) &&
                    (offset_q ? (phase_q == 2'd0) : (phase_q == 2'd3));
  assign eof      = complete && (word[71:64] == 8'h00);
  assign emit     = complete && !eof;
  assign bad      = emit && (word[71:64] != 8'hFF);

  // FSM: state register
  always_ff @(posedge CLK_IN or negedge IO_RESET_N) begin
    if (!IO_RESET_N) state_q <= ST_HUNT;
    else             state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT:   if (edge_even || edge_odd) state_d = ST_LOCKED;
      ST_LOCKED: if (eof)                   state_d = ST_HUNT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    rx_locked = (state_q == ST_LOCKED);
  end

  // Phase, offset and zero-run next state
  always_comb begin
    phase_d  = 2'd0;
    offset_d = offset_q;
    zrun_d   = zrun_odd;
    if (state_q == ST_HUNT) begin
      if (edge_even || edge_odd) begin
        phase_d  = 2'd1;
        offset_d = edge_odd;
      end
    end else begin
      phase_d = phase_q + 2'd1;
      if (eof) zrun_d = EOF_ZRUN;
    end
  end

  always_ff @(posedge CLK_IN or negedge IO_RESET_N) begin
    if (!IO_RESET_N) begin
      phase_q   <= 2'd0;
      zrun_q    <= 4'd0;
      offset_q  <= 1'b0;
      hist_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      phase_q  <= phase_d;
      zrun_q   <= zrun_d;
      offset_q <= offset_d;
      for (int i = 0; i < NLANES; i++) hist_q[i] <= hist_d[i][6:0];
      if (emit) data_q <= word;
      valid_q <= emit;
      err_q   <= bad;
      if (bad && !(&err_cnt_q)) err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign DATA_OUT_TO_DEVICE = data_q;
  assign DATA_VALID         = valid_q;
  assign RX_LOCKED          = rx_locked;
  assign BIT_OFFSET         = offset_q;
  assign ALIGN_ERR          = err_q;
  assign ERR_CNT            = err_cnt_q;

endmodule

// File: tb/tb_ewrapper_io_rx_deser.sv
// Testbench for ewrapper_io_rx_deser. Stimulus is built as a serial bit
// stream (one 9-lane slot per received bit). A bit-serial reference receiver
// walks that stream and predicts every cycle's outputs.
module tb_ewrapper_io_rx_deser;
  localparam int IDLE_MIN  = 8;
  localparam int ERR_CNT_W = 8;
  localparam int MAXC      = 2048;

  logic                 clk   = 1'b0;
  logic                 rst_n = 1'b0;
  logic [8:0]           ev    = '0;
  logic [8:0]           od    = '0;
  logic [71:0]          dout;
  logic                 dv, lck, boff, aerr;
  logic [ERR_CNT_W-1:0] ecnt;

  ewrapper_io_rx_deser #(.IDLE_MIN(IDLE_MIN), .ERR_CNT_W(ERR_CNT_W)) dut (
    .CLK_IN(clk), .IO_RESET_N(rst_n), .DATA_EVEN_IN(ev), .DATA_ODD_IN(od),
    .DATA_OUT_TO_DEVICE(dout), .DATA_VALID(dv), .RX_LOCKED(lck),
    .BIT_OFFSET(boff), .ALIGN_ERR(aerr), .ERR_CNT(ecnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [8:0] bitq[$];
  int         ncyc;

  logic        exp_v[MAXC], exp_e[MAXC], exp_l[MAXC], exp_o[MAXC];
  logic [71:0] exp_d[MAXC];
  logic [7:0]  exp_n[MAXC];
  logic        obs_v[MAXC], obs_e[MAXC], obs_l[MAXC], obs_o[MAXC];
  logic [71:0] obs_d[MAXC];
  logic [7:0]  obs_n[MAXC];

  // Reference receiver state
  logic        m_locked, m_off;
  int          m_zr, m_cnt, m_errs;
  logic [7:0]  m_by[9];
  logic [71:0] m_hold;

  task automatic model_reset();
    m_locked = 1'b0; m_off = 1'b0; m_zr = 0; m_cnt = 0; m_errs = 0; m_hold = '0;
    for (int k = 0; k < 9; k++) m_by[k] = 8'h00;
  endtask

  // Walk the serial stream bit by bit and predict per-cycle outputs.
  task automatic model_run();
    logic [8:0] b;
    logic       f, emit_c, err_c, skip, eof_now;
    if (bitq.size() % 2 != 0) bitq.push_back(9'h000);
    ncyc = bitq.size() / 2;
    for (int c = 0; c < ncyc; c++) begin
      emit_c = 1'b0; err_c = 1'b0; skip = 1'b0;
      for (int s = 0; s < 2; s++) begin
        if (!skip) begin
          b = bitq[2*c+s]; f = b[8]; eof_now = 1'b0;
          if (!m_locked && f && m_zr >= IDLE_MIN) begin
            m_locked = 1'b1; m_off = (s == 1); m_cnt = 0;
          end
          if (m_locked) begin
            for (int k = 0; k < 9; k++) m_by[k] = {m_by[k][6:0], b[k]};
            m_cnt++;
            if (m_cnt == 8) begin
              m_cnt = 0;
              if (m_by[8] == 8'h00) begin
                m_locked = 1'b0; m_zr = 8; eof_now = 1'b1; skip = 1'b1;
              end else begin
                emit_c = 1'b1;
                for (int k = 0; k < 9; k++) m_hold[8*k +: 8] = m_by[k];
                if (m_by[8] != 8'hFF) begin
                  err_c = 1'b1;
                  if (m_errs < 255) m_errs++;
                end
              end
            end
          end
          if (!eof_now) m_zr = f ? 0 : ((m_zr < 15) ? m_zr + 1 : 15);
        end
      end
      exp_v[c] = emit_c; exp_e[c] = err_c; exp_l[c] = m_locked; exp_o[c] = m_off;
      exp_d[c] = m_hold; exp_n[c] = 8'(m_errs);
    end
  endtask

  task automatic push_bit(input logic f);
    bitq.push_back({f, 8'($urandom)});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_bit(1'b0);
  endtask

  task automatic push_byte(input logic [7:0] fb, input logic [63:0] d);
    logic [8:0] slot;
    for (int i = 7; i >= 0; i--) begin
      slot[8] = fb[i];
      for (int k = 0; k < 8; k++) slot[k] = d[8*k+i];
      bitq.push_back(slot);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ev = '0; od = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive cycles 0..n-1 of the current stream and record outputs #1 after each edge.
  task automatic run_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      ev = bitq[2*c]; od = bitq[2*c+1];
      @(posedge clk); #1;
      obs_v[c] = dv; obs_e[c] = aerr; obs_l[c] = lck; obs_o[c] = boff;
      obs_d[c] = dout; obs_n[c] = ecnt;
      if (dv) $display("  word cyc=%0d data=%h align_err=%b err_cnt=%0d", c, dout, aerr, ecnt);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (dout !== 72'h0) begin errors++; $display("FAIL reset_data: got %h want 0", dout); end
    checks++; if (dv !== 1'b0)    begin errors++; $display("FAIL reset_valid: got %b want 0", dv); end
    checks++; if (lck !== 1'b0)   begin errors++; $display("FAIL reset_locked: got %b want 0", lck); end
    checks++; if (boff !== 1'b0)  begin errors++; $display("FAIL reset_offset: got %b want 0", boff); end
    checks++; if (aerr !== 1'b0)  begin errors++; $display("FAIL reset_alignerr: got %b want 0", aerr); end
    checks++; if (ecnt !== 8'h0)  begin errors++; $display("FAIL reset_errcnt: got %0d want 0", ecnt); end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
  endtask

  // Lock on an even or odd slot with the fixed 0x10+k data pattern.
  task automatic test_lock(input int idle_bits);
    int first;
    int want_first;
    do_reset();
    bitq.delete();
    push_idle(idle_bits);
    push_byte(8'hFF, 64'h1716151413121110);
    push_byte(8'h00, rnd64());
    push_idle(8);
    model_run();
    run_cycles(ncyc);
    first = -1;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_e[c] !== exp_e[c] || obs_l[c] !== exp_l[c] ||
          obs_o[c] !== exp_o[c] || obs_d[c] !== exp_d[c] || obs_n[c] !== exp_n[c]) begin
        errors++;
        $display("FAIL lock%0d cyc %0d: got v=%b e=%b l=%b o=%b n=%0d d=%h want v=%b e=%b l=%b o=%b n=%0d d=%h",
                 idle_bits % 2, c, obs_v[c], obs_e[c], obs_l[c], obs_o[c], obs_n[c], obs_d[c],
                 exp_v[c], exp_e[c], exp_l[c], exp_o[c], exp_n[c], exp_d[c]);
      end
      if (obs_v[c] === 1'b1 && first < 0) first = c;
    end
    // Edge bit index = idle_bits; offset-0 words need 3 more edges, offset-1 words 4.
    want_first = idle_bits / 2 + 3 + idle_bits % 2;
    checks++;
    if (first != want_first) begin
      errors++; $display("FAIL lock%0d_latency: strobe cycle %0d want %0d", idle_bits % 2, first, want_first);
    end else begin
      checks++;
      if (obs_d[first] !== 72'hFF_1716_1514_1312_1110) begin
        errors++; $display("FAIL lock%0d_word: got %h want ff1716151413121110", idle_bits % 2, obs_d[first]);
      end
      checks++;
      if (obs_o[first] !== 1'((idle_bits % 2))) begin
        errors++; $display("FAIL lock%0d_offset: got %b want %0d", idle_bits % 2, obs_o[first], idle_bits % 2);
      end
    end
  endtask

  task automatic test_frame_end();
    int n, nstb, s0, s1;
    do_reset();
    bitq.delete();
    n = $urandom_range(8, 13);
    push_idle(n);
    push_byte(8'hFF, rnd64());
    push_byte(8'hFF, rnd64());
    push_byte(8'h00, rnd64());
    push_idle(10);
    model_run();
    run_cycles(ncyc);
    nstb = 0; s0 = -1; s1 = -1;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_e[c] !== exp_e[c] || obs_l[c] !== exp_l[c] ||
          obs_o[c] !== exp_o[c] || obs_d[c] !== exp_d[c] || obs_n[c] !== exp_n[c]) begin
        errors++;
        $display("FAIL frame_end cyc %0d: got v=%b e=%b l=%b o=%b d=%h want v=%b e=%b l=%b o=%b d=%h",
                 c, obs_v[c], obs_e[c], obs_l[c], obs_o[c], obs_d[c],
                 exp_v[c], exp_e[c], exp_l[c], exp_o[c], exp_d[c]);
      end
      if (obs_v[c] === 1'b1) begin
        if (nstb == 0) s0 = c; else if (nstb == 1) s1 = c;
        nstb++;
      end
    end
    checks++;
    if (nstb != 2) begin errors++; $display("FAIL frame_end_count: got %0d strobes want 2", nstb); end
    checks++;
    if (s1 - s0 != 4) begin errors++; $display("FAIL frame_end_spacing: got %0d want 4", s1 - s0); end
    // Third word completes 8 cycles after the first one.
    checks++;
    if (obs_l[s0 + 8] !== 1'b0 || obs_l[s0 + 7] !== 1'b1) begin
      errors++; $display("FAIL frame_end_unlock: locked %b,%b want 1,0", obs_l[s0 + 7], obs_l[s0 + 8]);
    end
  endtask

  task automatic test_short_idle();
    int nstb;
    do_reset();
    bitq.delete();
    push_idle(4);  push_bit(1'b1);   // edge after 4 zeros
    push_idle(7);  push_bit(1'b1);   // edge after 7 zeros (one short)
    push_idle(8);                    // exactly IDLE_MIN zeros
    push_byte(8'hFF, rnd64());
    push_byte(8'h00, rnd64());
    push_idle(6);
    model_run();
    run_cycles(ncyc);
    nstb = 0;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_e[c] !== exp_e[c] || obs_l[c] !== exp_l[c] ||
          obs_o[c] !== exp_o[c] || obs_d[c] !== exp_d[c] || obs_n[c] !== exp_n[c]) begin
        errors++;
        $display("FAIL short_idle cyc %0d: got v=%b l=%b o=%b d=%h want v=%b l=%b o=%b d=%h",
                 c, obs_v[c], obs_l[c], obs_o[c], obs_d[c], exp_v[c], exp_l[c], exp_o[c], exp_d[c]);
      end
      if (obs_v[c] === 1'b1) nstb++;
    end
    // Bit 12 (cycle 6) is the second short edge: must still be hunting.
    checks++;
    if (obs_l[6] !== 1'b0) begin errors++; $display("FAIL short_idle_hunt: locked=%b want 0", obs_l[6]); end
    checks++;
    if (nstb != 1) begin errors++; $display("FAIL short_idle_count: got %0d strobes want 1", nstb); end
  endtask

  task automatic test_align_err();
    int naerr;
    do_reset();
    bitq.delete();
    push_idle($urandom_range(8, 12));
    push_byte(8'hFF, rnd64());
    push_byte(8'h3C, rnd64());
    push_byte(8'hFF, rnd64());
    push_byte(8'h00, rnd64());
    push_idle(8);
    model_run();
    run_cycles(ncyc);
    naerr = 0;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_e[c] !== exp_e[c] || obs_l[c] !== exp_l[c] ||
          obs_o[c] !== exp_o[c] || obs_d[c] !== exp_d[c] || obs_n[c] !== exp_n[c]) begin
        errors++;
        $display("FAIL align_err cyc %0d: got v=%b e=%b n=%0d d=%h want v=%b e=%b n=%0d d=%h",
                 c, obs_v[c], obs_e[c], obs_n[c], obs_d[c], exp_v[c], exp_e[c], exp_n[c], exp_d[c]);
      end
      if (obs_e[c] === 1'b1) naerr++;
    end
    checks++;
    if (naerr != 1) begin errors++; $display("FAIL align_err_pulses: got %0d want 1", naerr); end
    checks++;
    if (ecnt !== 8'd1) begin errors++; $display("FAIL align_err_cnt: got %0d want 1", ecnt); end

    // Saturation: keep the counter, run a long frame of malformed bytes.
    bitq.delete();
    push_idle(10);
    push_byte(8'hFF, rnd64());
    for (int i = 0; i < 260; i++) push_byte(8'($urandom_range(1, 254)), rnd64());
    push_byte(8'h00, rnd64());
    push_idle(4);
    model_run();
    run_cycles(ncyc);
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_e[c] !== exp_e[c] || obs_l[c] !== exp_l[c] ||
          obs_d[c] !== exp_d[c] || obs_n[c] !== exp_n[c]) begin
        errors++;
        $display("FAIL err_sat cyc %0d: got v=%b e=%b n=%0d want v=%b e=%b n=%0d",
                 c, obs_v[c], obs_e[c], obs_n[c], exp_v[c], exp_e[c], exp_n[c]);
      end
    end
    checks++;
    if (ecnt !== 8'hFF) begin errors++; $display("FAIL err_sat_final: got %h want ff", ecnt); end
  endtask

  task automatic test_reset_midword();
    int nstb;
    do_reset();
    bitq.delete();
    push_idle(11);                   // odd-slot lock, edge in cycle 5
    push_byte(8'hFF, rnd64());
    push_byte(8'h3C, rnd64());
    push_byte(8'hFF, rnd64());
    push_byte(8'h00, rnd64());
    push_idle(6);
    model_run();
    // Third word's phase-2 cycle is edge + 10 = cycle 15; run 0..14 first.
    run_cycles(15);
    for (int c = 0; c < 15; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_e[c] !== exp_e[c] || obs_l[c] !== exp_l[c] ||
          obs_o[c] !== exp_o[c] || obs_d[c] !== exp_d[c] || obs_n[c] !== exp_n[c]) begin
        errors++;
        $display("FAIL pre_reset cyc %0d: got v=%b l=%b o=%b n=%0d d=%h want v=%b l=%b o=%b n=%0d d=%h",
                 c, obs_v[c], obs_l[c], obs_o[c], obs_n[c], obs_d[c],
                 exp_v[c], exp_l[c], exp_o[c], exp_n[c], exp_d[c]);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== 72'h0 || dv !== 1'b0 || lck !== 1'b0 || boff !== 1'b0 || aerr !== 1'b0 || ecnt !== 8'h0) begin
      errors++;
      $display("FAIL midword_reset: got d=%h v=%b l=%b o=%b e=%b n=%0d want all 0", dout, dv, lck, boff, aerr, ecnt);
    end
    ev = '0; od = '0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (dv !== 1'b0 || lck !== 1'b0) begin
        errors++; $display("FAIL midword_hold %0d: got v=%b l=%b want 0,0", i, dv, lck);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    bitq.delete();
    push_idle($urandom_range(8, 13));
    push_byte(8'hFF, rnd64());
    push_byte(8'h00, rnd64());
    push_idle(6);
    model_run();
    run_cycles(ncyc);
    nstb = 0;
    for (int c = 0; c < ncyc; c++) begin
      checks++;
      if (obs_v[c] !== exp_v[c] || obs_e[c] !== exp_e[c] || obs_l[c] !== exp_l[c] ||
          obs_o[c] !== exp_o[c] || obs_d[c] !== exp_d[c] || obs_n[c] !== exp_n[c]) begin
        errors++;
        $display("FAIL relock cyc %0d: got v=%b l=%b o=%b d=%h want v=%b l=%b o=%b d=%h",
                 c, obs_v[c], obs_l[c], obs_o[c], obs_d[c], exp_v[c], exp_l[c], exp_o[c], exp_d[c]);
      end
      if (obs_v[c] === 1'b1) nstb++;
    end
    checks++;
    if (nstb != 1) begin errors++; $display("FAIL relock_count: got %0d strobes want 1", nstb); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock(10);
    test_lock(11);
    test_frame_end();
    test_short_idle();
    test_align_err();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
